// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin sequencer for a shared multicycle combinational divider
//
// Grants one of NREQ unsigned divide requests at a time, drives the granted
// operands onto the divider through registers, waits DIV_CYCLES edges for the
// divider to settle, then presents the quotient and flags on one response
// channel tagged with the requester index. A zero divisor is answered locally.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   req_valid[NREQ]               per-requester request valid
//   req_ready[NREQ]               per-requester accept strobe (one-hot or zero)
//   req_a, req_b [NREQ*N]         packed dividends / divisors, requester i at [i*N +: N]
//   rsp_valid, rsp_ready          response handshake
//   rsp_id                        owner of the response
//   rsp_c, rsp_zero, rsp_ovf, rsp_dbz   quotient and flags
//   busy                          an operation is in flight or awaiting retirement
//   div_a, div_b                  registered operands to the divider
//   div_c, div_zero, div_cout, div_overflow   divider results

module div_arbiter #(
    parameter int N          = 32,
    parameter int NREQ       = 4,
    parameter int DIV_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*N-1:0]         req_a,
    input  logic [NREQ*N-1:0]         req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [N-1:0]              rsp_c,
    output logic                      rsp_zero,
    output logic                      rsp_ovf,
    output logic                      rsp_dbz,
    output logic                      busy,
    output logic [N-1:0]              div_a,
    output logic [N-1:0]              div_b,
    input  logic [N-1:0]              div_c,
    input  logic                      div_zero,
    input  logic                      div_cout,
    input  logic                      div_overflow
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   grant_idx;
    logic            grant_found;
    logic            accept;
    logic [N-1:0]    a_arr [NREQ];
    logic [N-1:0]    b_arr [NREQ];
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*N +: N];
        assign b_arr[i] = req_b[i*N +: N];
    end

    // Round-robin scan starting at ptr, wrapping past NREQ-1 back to 0.
    // The sum is one bit wider so ptr + j never overflows before the wrap.
    always_comb begin
        logic [IW:0] scan;
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int j = 0; j < NREQ; j++) begin
            scan = {1'b0, ptr} + (IW+1)'(j);
            if (scan >= (IW+1)'(NREQ)) begin
                scan = scan - (IW+1)'(NREQ);
            end
            if (!grant_found && req_valid[scan[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[IW-1:0];
            end
        end
    end

    // No handshake may complete while reset is held, so the grant is masked by rst.
    assign accept = (state == IDLE) && grant_found && !rst;
    assign sel_a  = a_arr[grant_idx];
    assign sel_b  = b_arr[grant_idx];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (sel_b == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    // Operand, pointer, counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            cnt      <= '0;
            div_a    <= '0;
            div_b    <= '0;
            rsp_id   <= '0;
            rsp_c    <= '0;
            rsp_zero <= 1'b0;
            rsp_ovf  <= 1'b0;
            rsp_dbz  <= 1'b0;
        end else begin
            if (accept) begin
                div_a  <= sel_a;
                div_b  <= sel_b;
                rsp_id <= grant_idx;
                ptr    <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
                if (sel_b == '0) begin
                    // Answered without the divider: saturated quotient, dbz set.
                    rsp_c    <= '1;
                    rsp_dbz  <= 1'b1;
                    rsp_zero <= (sel_a == '0);
                    rsp_ovf  <= 1'b0;
                end else begin
                    cnt <= CW'(DIV_CYCLES - 1);
                end
            end
            if (state == WAIT) begin
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end else begin
                    // Divider has had DIV_CYCLES edges of stable inputs.
                    rsp_c    <= div_c;
                    rsp_zero <= div_zero;
                    rsp_ovf  <= div_cout | div_overflow;
                    rsp_dbz  <= 1'b0;
                end
            end
        end
    end

endmodule
